// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with load extraction, write-back mux and HALT detection
// Optional retired-instruction counter enabled by defining MEMWB_RETIRE_CNT_EN.
module mem_wb_stage #(
    parameter int msb  = 31,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_enable,
    input  logic            in_flush,
    input  logic            in_valid,
    input  logic [msb:0]    in_mem_data,
    input  logic [msb:0]    in_EXMEM_ALU,
    input  logic [RD_W-1:0] in_rd,
    input  logic [1:0]      in_regWB,
    input  logic [2:0]      in_ld_type,
    input  logic            in_halt,
    output logic [msb:0]    out_wb_data,
    output logic [RD_W-1:0] out_wb_rd,
    output logic            out_RegWrite,
    output logic            out_MEMWB_valid,
    output logic            out_halted,
    output logic [31:0]     out_retired
);

    logic [msb:0]    r_wb_data;
    logic [RD_W-1:0] r_wb_rd;
    logic            r_reg_write;
    logic            r_valid;
    logic            r_halted;

    logic            w_capture;
    logic            w_reg_write;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [msb:0]    w_load;
    logic [msb:0]    w_wb_data;

    // A retired HALT freezes the whole stage until reset.
    assign w_capture = in_enable && !r_halted;

    always_comb begin
        w_byte = in_mem_data[7:0];
        case (in_EXMEM_ALU[1:0])
            2'd0:    w_byte = in_mem_data[7:0];
            2'd1:    w_byte = in_mem_data[15:8];
            2'd2:    w_byte = in_mem_data[23:16];
            default: w_byte = in_mem_data[31:24];
        endcase
        w_half = in_EXMEM_ALU[1] ? in_mem_data[31:16] : in_mem_data[15:0];

        w_load = in_mem_data;
        case (in_ld_type[1:0])
            2'b00:   w_load = in_ld_type[2] ? {{(msb-7){1'b0}}, w_byte}
                                            : {{(msb-7){w_byte[7]}}, w_byte};
            2'b01:   w_load = in_ld_type[2] ? {{(msb-15){1'b0}}, w_half}
                                            : {{(msb-15){w_half[15]}}, w_half};
            default: w_load = in_mem_data;
        endcase

        w_wb_data   = in_regWB[0] ? w_load : in_EXMEM_ALU;
        w_reg_write = in_regWB[1] && in_valid && !in_halt && (in_rd != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wb_data   <= '0;
            r_wb_rd     <= '0;
            r_reg_write <= 1'b0;
            r_valid     <= 1'b0;
            r_halted    <= 1'b0;
        end else if (w_capture) begin
            if (in_flush) begin
                r_wb_data   <= '0;
                r_wb_rd     <= '0;
                r_reg_write <= 1'b0;
                r_valid     <= 1'b0;
            end else begin
                r_wb_data   <= w_wb_data;
                r_wb_rd     <= in_rd;
                r_reg_write <= w_reg_write;
                r_valid     <= in_valid;
                if (in_valid && in_halt)
                    r_halted <= 1'b1;
            end
        end
    end

`ifdef MEMWB_RETIRE_CNT_EN
    logic [31:0] r_retired;
    logic        w_retire;

    assign w_retire = w_capture && in_valid && !in_flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_retired <= 32'd0;
        else if (w_retire && (r_retired != 32'hFFFF_FFFF))
            r_retired <= r_retired + 32'd1;
    end

    assign out_retired = r_retired;
`else
    assign out_retired = 32'd0;
`endif

    assign out_wb_data     = r_wb_data;
    assign out_wb_rd       = r_wb_rd;
    assign out_RegWrite    = r_reg_write;
    assign out_MEMWB_valid = r_valid;
    assign out_halted      = r_halted;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage with a behavioural reference model
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_enable, in_flush, in_valid, in_halt;
    logic [31:0] in_mem_data, in_EXMEM_ALU;
    logic [4:0]  in_rd;
    logic [1:0]  in_regWB;
    logic [2:0]  in_ld_type;
    logic [31:0] out_wb_data;
    logic [4:0]  out_wb_rd;
    logic        out_RegWrite, out_MEMWB_valid, out_halted;
    logic [31:0] out_retired;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_data, m_retired;
    logic [4:0]  m_rd;
    logic        m_rw, m_valid, m_halted;

    mem_wb_stage #(.msb(31), .RD_W(5)) dut (
        .clk(clk), .reset(reset),
        .in_enable(in_enable), .in_flush(in_flush), .in_valid(in_valid),
        .in_mem_data(in_mem_data), .in_EXMEM_ALU(in_EXMEM_ALU), .in_rd(in_rd),
        .in_regWB(in_regWB), .in_ld_type(in_ld_type), .in_halt(in_halt),
        .out_wb_data(out_wb_data), .out_wb_rd(out_wb_rd), .out_RegWrite(out_RegWrite),
        .out_MEMWB_valid(out_MEMWB_valid), .out_halted(out_halted), .out_retired(out_retired)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_load(input logic [31:0] mem, input logic [31:0] addr,
                                             input logic [2:0] ldt);
        int unsigned a;
        logic [31:0] v;
        a = addr % 4;
        if (ldt[1:0] == 2'b00) begin
            v = (mem >> (8 * a)) & 32'hFF;
            if (!ldt[2] && v[7]) v = v | 32'hFFFF_FF00;
        end else if (ldt[1:0] == 2'b01) begin
            v = (a >= 2) ? (mem >> 16) : mem;
            v = v & 32'hFFFF;
            if (!ldt[2] && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = mem;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_data = 0; m_rd = 0; m_rw = 0; m_valid = 0; m_halted = 0; m_retired = 0;
    endtask

    task automatic model_edge();
        if (in_enable && !m_halted) begin
            if (in_flush) begin
                m_valid = 0; m_rw = 0; m_rd = 0; m_data = 0;
            end else begin
                m_valid = in_valid;
                m_rw    = in_regWB[1] && in_valid && !in_halt && (in_rd != 0);
                m_rd    = in_rd;
                m_data  = in_regWB[0] ? ref_load(in_mem_data, in_EXMEM_ALU, in_ld_type) : in_EXMEM_ALU;
                if (in_valid && in_halt) m_halted = 1;
`ifdef MEMWB_RETIRE_CNT_EN
                if (in_valid && m_retired != 32'hFFFF_FFFF) m_retired = m_retired + 1;
`endif
            end
        end
    endtask

    task automatic drive(input logic en, input logic fl, input logic v, input logic [31:0] mem,
                         input logic [31:0] alu, input logic [4:0] rd, input logic [1:0] wb,
                         input logic [2:0] ldt, input logic h);
        in_enable = en; in_flush = fl; in_valid = v; in_mem_data = mem; in_EXMEM_ALU = alu;
        in_rd = rd; in_regWB = wb; in_ld_type = ldt; in_halt = h;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #2;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        drive(1, 0, 1, 32'h1111_2222, 32'h3333_4444, 5'd7, 2'b10, 3'b010, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        #1;
        checks++; if (out_wb_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h exp 0", out_wb_data); end
        checks++; if (out_wb_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d exp 0", out_wb_rd); end
        checks++; if (out_RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %b exp 0", out_RegWrite); end
        checks++; if (out_MEMWB_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_MEMWB_valid); end
        checks++; if (out_halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", out_halted); end
        checks++; if (out_retired !== 32'd0) begin errors++; $display("FAIL reset_retired got %h exp 0", out_retired); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_loads();
        logic [31:0] lb_exp [4];
        lb_exp[0] = 32'h0000_0001; lb_exp[1] = 32'h0000_007F;
        lb_exp[2] = 32'hFFFF_FFFF; lb_exp[3] = 32'hFFFF_FF80;
        drive(1, 0, 1, 32'hDEAD_BEEF, 32'h10, 5'd8, 2'b11, 3'b010, 0);
        tick();
        checks++; if (out_wb_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_data got %h exp deadbeef", out_wb_data); end
        checks++; if (out_wb_rd !== 5'd8) begin errors++; $display("FAIL lw_rd got %0d exp 8", out_wb_rd); end
        checks++; if (out_RegWrite !== 1'b1) begin errors++; $display("FAIL lw_regwrite got %b exp 1", out_RegWrite); end
        for (int a = 0; a < 4; a++) begin
            drive(1, 0, 1, 32'h80FF_7F01, 32'h100 + a, 5'd9, 2'b11, 3'b000, 0);
            tick();
            checks++;
            if (out_wb_data !== lb_exp[a]) begin errors++; $display("FAIL lb_a%0d got %h exp %h", a, out_wb_data, lb_exp[a]); end
        end
        drive(1, 0, 1, 32'h80FF_7F01, 32'h103, 5'd9, 2'b11, 3'b100, 0);
        tick();
        checks++; if (out_wb_data !== 32'h0000_0080) begin errors++; $display("FAIL lbu_a3 got %h exp 00000080", out_wb_data); end
        drive(1, 0, 1, 32'h80FF_7F01, 32'h102, 5'd9, 2'b11, 3'b001, 0);
        tick();
        checks++; if (out_wb_data !== 32'hFFFF_80FF) begin errors++; $display("FAIL lh_a2 got %h exp ffff80ff", out_wb_data); end
        drive(1, 0, 1, 32'h80FF_7F01, 32'h103, 5'd9, 2'b11, 3'b101, 0);
        tick();
        checks++; if (out_wb_data !== 32'h0000_80FF) begin errors++; $display("FAIL lhu_a3 got %h exp 000080ff", out_wb_data); end
        drive(1, 0, 1, 32'h80FF_7F01, 32'h101, 5'd9, 2'b11, 3'b001, 0);
        tick();
        checks++; if (out_wb_data !== 32'h0000_7F01) begin errors++; $display("FAIL lh_a1 got %h exp 00007f01", out_wb_data); end
    endtask

    task automatic test_rtype();
        drive(1, 0, 1, 32'hAAAA_5555, 32'h1234, 5'd0, 2'b10, 3'b000, 0);
        tick();
        checks++; if (out_RegWrite !== 1'b0) begin errors++; $display("FAIL rtype_rd0_regwrite got %b exp 0", out_RegWrite); end
        checks++; if (out_wb_data !== 32'h1234) begin errors++; $display("FAIL rtype_rd0_data got %h exp 1234", out_wb_data); end
        drive(1, 0, 1, 32'hAAAA_5555, 32'h1234, 5'd5, 2'b10, 3'b000, 0);
        tick();
        checks++; if (out_RegWrite !== 1'b1) begin errors++; $display("FAIL rtype_rd5_regwrite got %b exp 1", out_RegWrite); end
        checks++; if (out_wb_data !== 32'h1234) begin errors++; $display("FAIL rtype_rd5_data got %h exp 1234", out_wb_data); end
        checks++; if (out_wb_rd !== 5'd5) begin errors++; $display("FAIL rtype_rd5_rd got %0d exp 5", out_wb_rd); end
    endtask

    task automatic test_hold_flush();
        logic [31:0] ret0;
        drive(1, 0, 1, 32'h0, 32'hCAFE_0001, 5'd12, 2'b10, 3'b010, 0);
        tick();
        ret0 = m_retired;
        for (int i = 0; i < 3; i++) begin
            drive(0, i[0], 1, $urandom, $urandom, 5'(i + 20), 2'b11, 3'b010, 0);
            tick();
            checks++;
            if (out_wb_data !== 32'hCAFE_0001 || out_wb_rd !== 5'd12 || out_RegWrite !== 1'b1 ||
                out_MEMWB_valid !== 1'b1 || out_retired !== ret0)
                begin errors++; $display("FAIL hold_%0d got data=%h rd=%0d rw=%b v=%b ret=%0d exp data=cafe0001 rd=12 rw=1 v=1 ret=%0d",
                    i, out_wb_data, out_wb_rd, out_RegWrite, out_MEMWB_valid, out_retired, ret0); end
        end
        drive(1, 1, 1, 32'h5, 32'h6, 5'd7, 2'b11, 3'b010, 0);
        tick();
        checks++; if (out_MEMWB_valid !== 1'b0 || out_RegWrite !== 1'b0 || out_wb_rd !== 5'd0 || out_wb_data !== 32'd0)
            begin errors++; $display("FAIL flush_bubble got v=%b rw=%b rd=%0d data=%h exp all 0", out_MEMWB_valid, out_RegWrite, out_wb_rd, out_wb_data); end
        checks++; if (out_retired !== ret0) begin errors++; $display("FAIL flush_retired got %0d exp %0d", out_retired, ret0); end
    endtask

    task automatic test_halt();
        logic [31:0] ret0;
        do_reset();
        drive(1, 1, 1, 32'h0, 32'h44, 5'd3, 2'b10, 3'b010, 1);
        tick();
        checks++; if (out_halted !== 1'b0) begin errors++; $display("FAIL halt_flush got %b exp 0", out_halted); end
        drive(1, 0, 1, 32'h0, 32'h77, 5'd3, 2'b10, 3'b010, 1);
        tick();
        ret0 = m_retired;
        checks++; if (out_halted !== 1'b1) begin errors++; $display("FAIL halt_set got %b exp 1", out_halted); end
        checks++; if (out_MEMWB_valid !== 1'b1 || out_RegWrite !== 1'b0)
            begin errors++; $display("FAIL halt_slot got v=%b rw=%b exp v=1 rw=0", out_MEMWB_valid, out_RegWrite); end
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, $urandom, 32'h900 + i, 5'd4, 2'b10, 3'b010, 0);
            tick();
            checks++;
            if (out_wb_data !== 32'h77 || out_halted !== 1'b1 || out_retired !== ret0)
                begin errors++; $display("FAIL halt_frozen_%0d got data=%h h=%b ret=%0d exp data=77 h=1 ret=%0d",
                    i, out_wb_data, out_halted, out_retired, ret0); end
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        checks++; if (out_halted !== 1'b0 || out_MEMWB_valid !== 1'b0)
            begin errors++; $display("FAIL halt_reset got h=%b v=%b exp 0 0", out_halted, out_MEMWB_valid); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_counter();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 1, $urandom, $urandom, 5'd1, 2'b10, 3'b010, 0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, $urandom, $urandom, 5'd1, 2'b10, 3'b010, 0);
            tick();
        end
        drive(1, 1, 1, $urandom, $urandom, 5'd1, 2'b10, 3'b010, 0);
        tick();
`ifdef MEMWB_RETIRE_CNT_EN
        checks++; if (out_retired !== 32'd5) begin errors++; $display("FAIL retired_count got %0d exp 5", out_retired); end
`else
        checks++; if (out_retired !== 32'd0) begin errors++; $display("FAIL retired_tied got %0d exp 0", out_retired); end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (m_halted && ($urandom_range(0, 3) == 0)) begin
                do_reset();
            end
            drive($urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 4) != 0,
                  $urandom, $urandom, 5'($urandom), 2'($urandom), 3'($urandom), $urandom_range(0, 40) == 0);
            tick();
            checks++;
            if (out_wb_data !== m_data || out_wb_rd !== m_rd || out_RegWrite !== m_rw ||
                out_MEMWB_valid !== m_valid || out_halted !== m_halted || out_retired !== m_retired)
                begin errors++; $display("FAIL random_%0d got data=%h rd=%0d rw=%b v=%b h=%b ret=%0d exp data=%h rd=%0d rw=%b v=%b h=%b ret=%0d",
                    n, out_wb_data, out_wb_rd, out_RegWrite, out_MEMWB_valid, out_halted, out_retired,
                    m_data, m_rd, m_rw, m_valid, m_halted, m_retired); end
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        test_reset();
        test_loads();
        test_rtype();
        test_hold_flush();
        test_halt();
        test_counter();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
